// File: rtl/writeback_pc_update_pkg.sv
// Shared Y86-64 constants for the writeback / PC-update stage: instruction codes,
// processor status encodings and the special register specifiers.
package writeback_pc_update_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'd4;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

endpackage

// File: rtl/writeback_pc_update_if.sv
// Bundle between the memory stage / decode and the writeback stage: the committing
// instruction's stage outputs, the decode read ports and the architectural state outputs.
interface writeback_pc_update_if;
  import writeback_pc_update_pkg::*;

  logic        commit;
  logic [3:0]  in_code;
  logic        cnd;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [63:0] val_c;
  logic [63:0] val_p;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic        bad_mem1;
  logic        bad_mem2;
  logic        bad_instr;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] pc;
  stat_e       stat;
  logic [63:0] retired;

  modport master (
    output commit, in_code, cnd, r_a, r_b, val_c, val_p, val_e, val_m,
           bad_mem1, bad_mem2, bad_instr, src_a, src_b,
    input  rd_a, rd_b, pc, stat, retired
  );

  modport slave (
    input  commit, in_code, cnd, r_a, r_b, val_c, val_p, val_e, val_m,
           bad_mem1, bad_mem2, bad_instr, src_a, src_b,
    output rd_a, rd_b, pc, stat, retired
  );

endinterface

// File: rtl/writeback_pc_update_regfile.sv
// Y86-64 register file: 15 x 64-bit, two combinational read ports, E and M write
// ports where M wins on a shared destination; %rsp resets to STACK_INIT.
module writeback_pc_update_regfile
  import writeback_pc_update_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd1023
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  // RNONE (4'hF) matches no entry, so writes to it fall away naturally.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      if (we_m && (dst_m == 4'(i))) begin
        regs_d[i] = val_m;
      end else if (we_e && (dst_e == 4'(i))) begin
        regs_d[i] = val_e;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? STACK_INIT : 64'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see pre-edge contents; no bypass from the write ports.
  always_comb begin
    if (src_a == RNONE) begin
      rd_a = 64'd0;
    end else begin
      rd_a = regs_q[src_a];
    end
    if (src_b == RNONE) begin
      rd_b = 64'd0;
    end else begin
      rd_b = regs_q[src_b];
    end
  end

endmodule

// File: rtl/writeback_pc_update.sv
// Final SEQ stage: commits val_e/val_m to the register file, registers the next PC,
// and owns the status and retired-instruction registers.
module writeback_pc_update
  import writeback_pc_update_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [63:0] STACK_INIT = 64'd1023
) (
  input  logic                  clock,
  input  logic                  reset_n,
  writeback_pc_update_if.slave  wb
);

  logic [3:0]  dst_e_s;
  logic [3:0]  dst_m_s;
  logic [63:0] new_pc_s;
  stat_e       next_stat_s;
  logic        we_s;

  logic [63:0] pc_q, pc_d;
  stat_e       stat_q, stat_d;
  logic [63:0] retired_q, retired_d;

  always_comb begin
    case (wb.in_code)
      I_CMOVXX:                        dst_e_s = wb.cnd ? wb.r_b : RNONE;
      I_IRMOVQ, I_OPQ:                 dst_e_s = wb.r_b;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e_s = RSP;
      default:                         dst_e_s = RNONE;
    endcase
    case (wb.in_code)
      I_MRMOVQ, I_POPQ: dst_m_s = wb.r_a;
      default:          dst_m_s = RNONE;
    endcase
    case (wb.in_code)
      I_JXX:   new_pc_s = wb.cnd ? wb.val_c : wb.val_p;
      I_CALL:  new_pc_s = wb.val_c;
      I_RET:   new_pc_s = wb.val_m;
      default: new_pc_s = wb.val_p;
    endcase
    if (wb.bad_mem1 || wb.bad_mem2) begin
      next_stat_s = STAT_ADR;
    end else if (wb.bad_instr) begin
      next_stat_s = STAT_INS;
    end else if (wb.in_code == I_HALT) begin
      next_stat_s = STAT_HLT;
    end else begin
      next_stat_s = STAT_AOK;
    end
  end

  // Any non-AOK status is terminal; only a commit while AOK moves state.
  always_comb begin
    pc_d      = pc_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    we_s      = 1'b0;
    if (wb.commit && (stat_q == STAT_AOK)) begin
      stat_d = next_stat_s;
      case (next_stat_s)
        STAT_AOK: begin
          pc_d      = new_pc_s;
          retired_d = retired_q + 64'd1;
          we_s      = 1'b1;
        end
        STAT_HLT: retired_d = retired_q + 64'd1;
        default:  retired_d = retired_q;
      endcase
    end else begin
      stat_d = stat_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      retired_q <= 64'd0;
    end else begin
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  writeback_pc_update_regfile #(
    .STACK_INIT (STACK_INIT)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .src_a   (wb.src_a),
    .src_b   (wb.src_b),
    .rd_a    (wb.rd_a),
    .rd_b    (wb.rd_b),
    .we_e    (we_s),
    .dst_e   (dst_e_s),
    .val_e   (wb.val_e),
    .we_m    (we_s),
    .dst_m   (dst_m_s),
    .val_m   (wb.val_m)
  );

  assign wb.pc      = pc_q;
  assign wb.stat    = stat_q;
  assign wb.retired = retired_q;

endmodule

// File: tb/tb_writeback_pc_update.sv
// Scoreboard bench for writeback_pc_update: directed Y86 sequences plus random traffic,
// checked against an architectural model of PC, status, retired count and registers.
module tb_writeback_pc_update;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  writeback_pc_update_if wb ();

  writeback_pc_update #(
    .RESET_PC   (64'd0),
    .STACK_INIT (64'd1023)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (wb)
  );

  typedef struct {
    bit        commit;
    bit [3:0]  icode;
    bit        cnd;
    bit [3:0]  ra, rb;
    bit [63:0] vc, vp, ve, vm;
    bit        b1, b2, bi;
    bit [3:0]  sa, sb;
  } stim_t;

  typedef struct {
    logic [63:0] pc, retired, rd_a, rd_b;
    logic [2:0]  stat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Architectural model: plain array of registers and scalar state.
  logic [63:0] m_regs [15];
  logic [63:0] m_pc, m_ret;
  logic [2:0]  m_stat;

  function automatic logic [63:0] m_read(input logic [3:0] sel);
    return (sel == 4'hF) ? 64'd0 : m_regs[sel];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_regs[4] = 64'd1023;
    m_pc = 64'd0;
    m_ret = 64'd0;
    m_stat = 3'd1;
  endfunction

  function automatic void model_step(input stim_t s);
    logic [2:0] ns;
    logic [3:0] de, dm;
    if (!s.commit || m_stat != 3'd1) return;
    if (s.b1 || s.b2) ns = 3'd3;
    else if (s.bi) ns = 3'd4;
    else if (s.icode == 4'd0) ns = 3'd2;
    else ns = 3'd1;
    m_stat = ns;
    if (ns == 3'd2) m_ret = m_ret + 64'd1;
    if (ns != 3'd1) return;
    de = 4'hF;
    dm = 4'hF;
    if (s.icode == 4'd2 && s.cnd) de = s.rb;
    if (s.icode == 4'd3 || s.icode == 4'd6) de = s.rb;
    if (s.icode >= 4'd8 && s.icode <= 4'd11) de = 4'd4;
    if (s.icode == 4'd5 || s.icode == 4'd11) dm = s.ra;
    if (de != 4'hF) m_regs[de] = s.ve;
    if (dm != 4'hF) m_regs[dm] = s.vm;
    if (s.icode == 4'd7 && s.cnd) m_pc = s.vc;
    else if (s.icode == 4'd8) m_pc = s.vc;
    else if (s.icode == 4'd9) m_pc = s.vm;
    else m_pc = s.vp;
    m_ret = m_ret + 64'd1;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.commit = ($urandom_range(0, 4) != 0);
    s.icode  = ($urandom_range(0, 29) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
    s.cnd    = 1'($urandom);
    s.ra     = 4'($urandom);
    s.rb     = 4'($urandom);
    s.vc     = {$urandom, $urandom};
    s.vp     = {$urandom, $urandom};
    s.ve     = {$urandom, $urandom};
    s.vm     = {$urandom, $urandom};
    s.b1     = ($urandom_range(0, 39) == 0);
    s.b2     = ($urandom_range(0, 39) == 0);
    s.bi     = ($urandom_range(0, 39) == 0);
    s.sa     = 4'($urandom);
    s.sb     = 4'($urandom);
    return s;
  endfunction

  function automatic stim_t clean(input logic [3:0] icode);
    stim_t s;
    s = rnd_stim();
    s.commit = 1'b1;
    s.icode = icode;
    s.b1 = 1'b0;
    s.b2 = 1'b0;
    s.bi = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    wb.commit = s.commit;   wb.in_code = s.icode; wb.cnd = s.cnd;
    wb.r_a = s.ra;          wb.r_b = s.rb;
    wb.val_c = s.vc;        wb.val_p = s.vp;      wb.val_e = s.ve; wb.val_m = s.vm;
    wb.bad_mem1 = s.b1;     wb.bad_mem2 = s.b2;   wb.bad_instr = s.bi;
    wb.src_a = s.sa;        wb.src_b = s.sb;
  endtask

  task automatic push_exp(input stim_t s);
    exp_t e;
    e.pc = m_pc;
    e.retired = m_ret;
    e.stat = m_stat;
    e.rd_a = m_read(s.sa);
    e.rd_b = m_read(s.sb);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clock);
    apply(s);
    @(posedge clock);
    #1;
    model_step(s);
    push_exp(s);
  endtask

  // Reset lands mid-stream with a live commit that must be discarded.
  task automatic do_reset();
    stim_t s;
    s = clean(4'd3);
    @(negedge clock);
    apply(s);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    push_exp(s);
    @(negedge clock);
    wb.commit = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: each cycle, compare the presented state against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", wb.pc, e.pc);
        chk("stat", 64'(wb.stat), 64'(e.stat));
        chk("retired", wb.retired, e.retired);
        chk("rd_a", wb.rd_a, e.rd_a);
        chk("rd_b", wb.rd_b, e.rd_b);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    apply(clean(4'd1));
    wb.commit = 1'b0;
    do_reset();

    s = clean(4'd3); s.ra = 4'hF; s.rb = 4'd3; s.ve = 64'h2A; s.vp = 64'hA;
    s.sa = 4'd3; s.sb = 4'd4; drive(s);
    s = clean(4'd2); s.cnd = 1'b0; s.rb = 4'd2; s.ve = 64'd5; s.vp = 64'h14;
    s.sa = 4'd2; s.sb = 4'd3; drive(s);
    s = clean(4'd11); s.ra = 4'd4; s.rb = 4'hF; s.ve = 64'h3F8; s.vm = 64'h77;
    s.vp = 64'h16; s.sa = 4'd4; s.sb = 4'hF; drive(s);
    s = clean(4'd7); s.cnd = 1'b1; s.vc = 64'h40; s.vp = 64'h1F; s.sa = 4'd4; drive(s);
    s = clean(4'd9); s.vm = 64'h100; s.vp = 64'h41; s.ve = 64'h400; s.sa = 4'd4; drive(s);
    s = rnd_stim(); s.commit = 1'b0; drive(s);

    s = clean(4'd4); s.b2 = 1'b1; s.sa = 4'd3; s.sb = 4'd4; drive(s);
    repeat (2) begin
      s = clean(4'd3); s.rb = 4'd1; s.sa = 4'd1; drive(s);
    end
    do_reset();
    s = rnd_stim(); s.commit = 1'b0; s.sa = 4'd4; s.sb = 4'd3; drive(s);

    s = clean(4'd6); s.rb = 4'd7; s.sa = 4'd7; drive(s);
    s = clean(4'd0); s.sa = 4'd7; drive(s);
    s = rnd_stim(); s.commit = 1'b0; s.sa = 4'd7; drive(s);
    s = clean(4'd3); s.rb = 4'd7; s.sa = 4'd7; drive(s);

    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_stat != 3'd1 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        drive(rnd_stim());
      end
    end

    repeat (4) @(posedge clock);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
